// File: rtl/image_pkg.sv
// Shared pixel, window and state types for the image pipeline stages.
package image_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Element 0 is p1 (top-left), element 8 is p9 (bottom-right).
    typedef pixel_t [8:0] window_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// Fixed-depth pixel delay line: each shifted-in pixel reappears DEPTH shifts later.
module line_buffer
    import image_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   shift,
    input  pixel_t pixel,
    output pixel_t delayed
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    pixel_t           mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Circular buffer: the slot about to be overwritten holds the oldest pixel.
    assign delayed = mem[ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= pixel;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Raster-order pixel stream to registered 3x3 neighbourhood windows for interior centre pixels.
module window_generator
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic [7:0] p1,
    output logic [7:0] p2,
    output logic [7:0] p3,
    output logic [7:0] p4,
    output logic [7:0] p5,
    output logic [7:0] p6,
    output logic [7:0] p7,
    output logic [7:0] p8,
    output logic [7:0] p9,
    output logic       window_valid,
    output logic       frame_done,
    output logic       busy
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_t           state;
    state_t           next_state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             accept;
    logic             last_pixel;
    logic             interior;
    pixel_t           above1;
    pixel_t           above2;
    window_t          win;

    // A start pulse relabels any pixel arriving with it as (0,0), whatever the state.
    assign accept     = in_valid && (start || state == ACTIVE);
    assign cur_col    = start ? '0 : col;
    assign cur_row    = start ? '0 : row;
    assign last_pixel = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    assign interior   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ACTIVE;
        end else begin
            unique case (state)
                IDLE:    next_state = IDLE;
                ACTIVE:  next_state = (accept && last_pixel) ? DONE : ACTIVE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col <= cur_col + 1'b1;
                row <= cur_row;
            end
        end else if (start) begin
            col <= '0;
            row <= '0;
        end
    end

    // Chained delay lines present rows r-1 and r-2 of the current column.
    line_buffer #(
        .DEPTH(IMG_WIDTH)
    ) u_line1 (
        .clk    (clk),
        .n_rst  (n_rst),
        .shift  (accept),
        .pixel  (in_pixel),
        .delayed(above1)
    );

    line_buffer #(
        .DEPTH(IMG_WIDTH)
    ) u_line2 (
        .clk    (clk),
        .n_rst  (n_rst),
        .shift  (accept),
        .pixel  (above1),
        .delayed(above2)
    );

    // Three row shift registers; the window is only qualified once rows and columns refilled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win <= '0;
        end else if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= above2;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= above1;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            window_valid <= 1'b0;
        end else begin
            window_valid <= accept && interior;
        end
    end

    assign p1 = win[0];
    assign p2 = win[1];
    assign p3 = win[2];
    assign p4 = win[3];
    assign p5 = win[4];
    assign p6 = win[5];
    assign p7 = win[6];
    assign p8 = win[7];
    assign p9 = win[8];

endmodule

// File: tb/tb_window_generator.sv
// Self-checking bench for window_generator on a 5x4 frame against a frame-array reference model.
module tb_window_generator;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct {
        bit         s;
        bit         v;
        logic [7:0] px;
    } stim_t;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       in_valid;
    logic [7:0] in_pixel;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       window_valid;
    logic       frame_done;
    logic       busy;

    int errors;
    int checks;

    // Reference model: pixels of the current frame stored by arrival order.
    bit          m_active;
    int          m_n;
    logic [7:0]  m_frame [W*H];
    bit          exp_wv;
    bit          exp_fd;
    bit          exp_busy;
    bit          exp_hold;
    bit          hold_armed;
    logic [71:0] exp_vec;
    logic [71:0] last_win;

    window_generator #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_pixel    (in_pixel),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .p5          (p5),
        .p6          (p6),
        .p7          (p7),
        .p8          (p8),
        .p9          (p9),
        .window_valid(window_valid),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] obs_win();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    // Drive one cycle, predict the post-edge outputs, then sample 1 time unit after the edge.
    task automatic cycle(input bit s, input bit v, input logic [7:0] px);
        bit acc;
        int r;
        int c;
        start    = s;
        in_valid = v;
        in_pixel = px;
        acc      = v && (s || m_active);
        if (s) begin
            m_active = 1'b1;
            m_n      = 0;
        end
        exp_wv   = 1'b0;
        exp_fd   = 1'b0;
        exp_hold = hold_armed && !acc;
        if (acc) begin
            hold_armed = 1'b0;
            r = m_n / W;
            c = m_n % W;
            m_frame[m_n] = px;
            if (r >= 2 && c >= 2) begin
                exp_wv = 1'b1;
                exp_vec = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_vec = {exp_vec[63:0], m_frame[(r-2+i)*W + (c-2+j)]};
                last_win   = exp_vec;
                hold_armed = 1'b1;
            end
            m_n++;
            if (m_n == W*H) begin
                m_active = 1'b0;
                exp_fd   = 1'b1;
            end
        end
        exp_busy = m_active || exp_fd;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_n        = 0;
        hold_armed = 1'b0;
    endtask

    task automatic test_reset();
        logic [71:0] zero_win;
        zero_win = '0;
        n_rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
        model_reset();
        #3;
        checks += 4;
        if (obs_win() !== zero_win) begin errors++; $display("[TB] FAIL reset_window: got %h expected %h", obs_win(), zero_win); end
        if (window_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", window_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 14; k++) cycle(1'b0, 1'b1, 8'($urandom_range(1, 255)));
        #2;
        in_valid = 1'b1;
        n_rst    = 1'b0;
        #1;
        model_reset();
        checks += 4;
        if (obs_win() !== zero_win) begin errors++; $display("[TB] FAIL midreset_window: got %h expected %h", obs_win(), zero_win); end
        if (window_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b expected 0", window_valid); end
        if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", frame_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL release_busy: got %b expected 0", busy); end
        if (window_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected 0", window_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic_frame();
        stim_t q[$];
        int    wins;
        bit    first;
        logic [7:0]  last_p5;
        logic [71:0] first_req;
        first_req = {8'd0, 8'd1, 8'd2, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
        wins = 0; first = 1'b1; last_p5 = '0;
        q.push_back('{1'b1, 1'b0, 8'h00});
        for (int k = 0; k < W*H; k++) q.push_back('{1'b0, 1'b1, 8'(10*(k/W) + k%W)});
        q.push_back('{1'b0, 1'b0, 8'h00});
        foreach (q[i]) begin
            cycle(q[i].s, q[i].v, q[i].px);
            checks += 3;
            if (window_valid !== exp_wv) begin errors++; $display("[TB] FAIL basic_valid cycle %0d: got %b expected %b", i, window_valid, exp_wv); end
            if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL basic_done cycle %0d: got %b expected %b", i, frame_done, exp_fd); end
            if (busy !== exp_busy) begin errors++; $display("[TB] FAIL basic_busy cycle %0d: got %b expected %b", i, busy, exp_busy); end
            if (exp_wv) begin
                checks++;
                if (obs_win() !== exp_vec) begin errors++; $display("[TB] FAIL basic_window cycle %0d: got %h expected %h", i, obs_win(), exp_vec); end
            end
            if (window_valid === 1'b1) begin
                wins++;
                last_p5 = p5;
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (obs_win() !== first_req) begin errors++; $display("[TB] FAIL basic_first_window: got %h expected %h", obs_win(), first_req); end
                end
            end
        end
        checks += 2;
        if (wins !== (W-2)*(H-2)) begin errors++; $display("[TB] FAIL basic_count: got %0d expected %0d", wins, (W-2)*(H-2)); end
        if (last_p5 !== 8'd23) begin errors++; $display("[TB] FAIL basic_last_p5: got %0d expected 23", last_p5); end
    endtask

    task automatic test_gapped();
        stim_t q[$];
        q.push_back('{1'b1, 1'b0, 8'h00});
        for (int k = 0; k < W*H; k++) begin
            q.push_back('{1'b0, 1'b1, 8'($urandom)});
            repeat ($urandom_range(0, 2)) q.push_back('{1'b0, 1'b0, 8'($urandom)});
        end
        q.push_back('{1'b0, 1'b0, 8'h00});
        foreach (q[i]) begin
            cycle(q[i].s, q[i].v, q[i].px);
            checks += 2;
            if (window_valid !== exp_wv) begin errors++; $display("[TB] FAIL gap_valid cycle %0d: got %b expected %b", i, window_valid, exp_wv); end
            if (frame_done !== exp_fd) begin errors++; $display("[TB] FAIL gap_done cycle %0d: got %b expected %b", i, frame_done, exp_fd); end
            if (exp_wv) begin
                checks++;
                if (obs_win() !== exp_vec) begin errors++; $display("[TB] FAIL gap_window cycle %0d: got %h expected %h", i, obs_win(), exp_vec); end
            end
            if (exp_hold) begin
                checks++;
                if (obs_win() !== last_win) begin errors++; $display("[TB] FAIL gap_hold cycle %0d: got %h expected %h", i, obs_win(), last_win); end
            end
        end
    endtask

    task automatic test_border();
        stim_t q[$];
        int    wins;
        wins = 0;
        q.push_back('{1'b1, 1'b0, 8'h00});
        for (int k = 0; k < W*H; k++) q.push_back('{1'b0, 1'b1, 8'($urandom)});
        q.push_back('{1'b0, 1'b0, 8'h00});
        foreach (q[i]) begin
            cycle(q[i].s, q[i].v, q[i].px);
            checks++;
            if (window_valid !== exp_wv) begin errors++; $display("[TB] FAIL border_valid cycle %0d: got %b expected %b", i, window_valid, exp_wv); end
            if (window_valid === 1'b1) wins++;
        end
        checks++;
        if (wins !== (W-2)*(H-2)) begin errors++; $display("[TB] FAIL border_count: got %0d expected %0d", wins, (W-2)*(H-2)); end
    endtask

    task automatic test_abort();
        stim_t q[$];
        int    wins;
        int    dones;
        bit    first;
        wins = 0; dones = 0; first = 1'b1;
        q.push_back('{1'b1, 1'b0, 8'h00});
        for (int k = 0; k < 8; k++) q.push_back('{1'b0, 1'b1, 8'($urandom)});
        q.push_back('{1'b1, 1'b1, 8'h00});
        for (int k = 1; k < W*H; k++) q.push_back('{1'b0, 1'b1, 8'(10*(k/W) + k%W)});
        q.push_back('{1'b0, 1'b0, 8'h00});
        foreach (q[i]) begin
            cycle(q[i].s, q[i].v, q[i].px);
            checks++;
            if (window_valid !== exp_wv) begin errors++; $display("[TB] FAIL abort_valid cycle %0d: got %b expected %b", i, window_valid, exp_wv); end
            if (frame_done === 1'b1) dones++;
            if (window_valid === 1'b1) begin
                wins++;
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (p5 !== 8'd11) begin errors++; $display("[TB] FAIL abort_first_p5: got %0d expected 11", p5); end
                end
            end
        end
        checks += 2;
        if (wins !== (W-2)*(H-2)) begin errors++; $display("[TB] FAIL abort_count: got %0d expected %0d", wins, (W-2)*(H-2)); end
        if (dones !== 1) begin errors++; $display("[TB] FAIL abort_done_count: got %0d expected 1", dones); end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        int    wins;
        int    dones;
        wins = 0; dones = 0;
        q.push_back('{1'b1, 1'b0, 8'h00});
        for (int k = 0; k < W*H; k++) q.push_back('{1'b0, 1'b1, 8'($urandom)});
        q.push_back('{1'b1, 1'b1, 8'($urandom)});
        for (int k = 1; k < W*H; k++) q.push_back('{1'b0, 1'b1, 8'($urandom)});
        q.push_back('{1'b0, 1'b0, 8'h00});
        foreach (q[i]) begin
            cycle(q[i].s, q[i].v, q[i].px);
            checks += 2;
            if (window_valid !== exp_wv) begin errors++; $display("[TB] FAIL b2b_valid cycle %0d: got %b expected %b", i, window_valid, exp_wv); end
            if (busy !== exp_busy) begin errors++; $display("[TB] FAIL b2b_busy cycle %0d: got %b expected %b", i, busy, exp_busy); end
            if (exp_wv) begin
                checks++;
                if (obs_win() !== exp_vec) begin errors++; $display("[TB] FAIL b2b_window cycle %0d: got %h expected %h", i, obs_win(), exp_vec); end
            end
            if (i < q.size() - 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_held cycle %0d: got %b expected 1", i, busy); end
            end
            if (window_valid === 1'b1) wins++;
            if (frame_done === 1'b1) dones++;
        end
        checks += 2;
        if (wins !== 2*(W-2)*(H-2)) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected %0d", wins, 2*(W-2)*(H-2)); end
        if (dones !== 2) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", dones); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic_frame();
        test_gapped();
        test_border();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
